// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller driving one full-adder cell.
// Operands are captured on an in_valid/in_ready handshake. One bit is
// processed per clock, LSB first. The result is held on s/cout/ovf until
// the consumer takes it through the out_valid/out_ready handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic fa_a, fa_b, fa_sum, fa_cout;

    // The single full-adder cell, fed by the bit selected by the counter.
    assign fa_a    = opa[cnt];
    assign fa_b    = opb[cnt];
    assign fa_sum  = fa_a ^ fa_b ^ carry;
    assign fa_cout = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));

    // Held low during reset so nothing is offered while the block is cleared;
    // acceptance is still possible on the first edge after deassert.
    assign in_ready = (state == IDLE) && !reset;

    // Controller FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1; the external carry-in is ignored.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        s     <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[cnt] <= fa_sum;
                    carry  <= fa_cout;
                    if (cnt == LAST) begin
                        // carry here is the carry into the MSB.
                        cout      <= fa_cout;
                        ovf       <= carry ^ fa_cout;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random
// operations, compared against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modulo arithmetic; returns {ovf, cout, s}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic         v;
        bb  = msub ? ~mb : mb;
        sum = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
        v   = (ma[W-1] == bb[W-1]) && (sum[W-1] != ma[W-1]);
        return {v, sum};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic tsub, input int hold,
                          output logic [W-1:0] os, output logic oc, output logic oo);
        logic [W+1:0] e;
        e = model(ta, tb_v, tcin, tsub);
        chk("in_ready_idle", in_ready, 1);
        chk("busy_idle", busy, 0);
        in_valid = 1'b1; a = ta; b = tb_v; cin = tcin; sub = tsub; out_ready = 1'b0;
        @(posedge clk);  // accept edge
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("run_busy", busy, 1);
            chk("run_no_valid", out_valid, 0);
            chk("run_in_ready", in_ready, 0);
            // Inputs scrambled after acceptance must not matter.
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
        end
        @(negedge clk);
        chk("done_valid", out_valid, 1);
        chk("done_busy", busy, 0);
        chk("result", {ovf, cout, s}, e);
        os = s; oc = cout; oo = ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", {ovf, cout, s}, e);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("xfer_valid_drop", out_valid, 0);
        chk("xfer_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc, ro, ok;

        // Reset asserted from time 0.
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out", {out_valid, busy, cout, ovf, s}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(negedge clk);

        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 0, rs, rc, ro);
        chk("add_basic", {ro, rc, rs}, {1'b0, 1'b0, 8'h4B});
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, rs, rc, ro);
        chk("add_carry", {ro, rc, rs}, {1'b0, 1'b1, 8'h00});
        run_op(8'h7F, 8'h01, 1'b1, 1'b0, 1, rs, rc, ro);
        chk("add_ovf", {ro, rc, rs}, {1'b1, 1'b0, 8'h81});
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, rs, rc, ro);
        chk("sub_borrow", {ro, rc, rs}, {1'b0, 1'b0, 8'hFE});
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 0, rs, rc, ro);
        chk("sub_ovf", {ro, rc, rs}, {1'b1, 1'b1, 8'h7F});
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 5, rs, rc, ro);
        chk("backpressure", {ro, rc, rs}, {1'b0, 1'b0, 8'h46});

        // Abort: reset mid-cycle after three bits have been processed.
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out", {out_valid, busy, cout, ovf, s}, 0);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0 || s !== '0) ok = 1'b0;
        end
        chk("abort_quiet", ok, 1);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, rs, rc, ro);
        chk("after_abort", {ro, rc, rs}, {1'b0, 1'b0, 8'h02});

        // Random operations with random backpressure.
        for (int n = 0; n < 30; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), rs, rc, ro);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
